// File: rtl/maze_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : maze_port_arbiter_if
// Description : Bundles the requester side (req / coordinates / grant /
//               response) and the maze ROM port of maze_port_arbiter.
//               Port summary:
//                 req[NREQ], req_x[NREQ*X_W], req_y[NREQ*Y_W]  requester -> arb
//                 gnt[NREQ], rsp_valid[NREQ], rsp_data[DATA_W] arb -> requester
//                 rom_en, rom_x[X_W], rom_y[Y_W]               arb -> ROM
//                 rom_data[DATA_W]                             ROM -> arb
//               modport slave  : the arbiter's view
//               modport master : the environment (requesters + ROM) view
// Revision    : 1.0 - initial release
// ============================================================================
interface maze_port_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int X_W    = 10,
   parameter int Y_W    = 10,
   parameter int DATA_W = 4
);
   logic [NREQ-1:0]     req;
   logic [NREQ*X_W-1:0] req_x;
   logic [NREQ*Y_W-1:0] req_y;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rsp_valid;
   logic [DATA_W-1:0]   rsp_data;
   logic                rom_en;
   logic [X_W-1:0]      rom_x;
   logic [Y_W-1:0]      rom_y;
   logic [DATA_W-1:0]   rom_data;

   modport slave (
      input  req, req_x, req_y, rom_data,
      output gnt, rsp_valid, rsp_data, rom_en, rom_x, rom_y
   );

   modport master (
      output req, req_x, req_y, rom_data,
      input  gnt, rsp_valid, rsp_data, rom_en, rom_x, rom_y
   );
endinterface

`default_nettype wire

// File: rtl/maze_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maze_port_arbiter
// Description : Shares the single-port maze ROM between the pacman movement
//               FSM (requester 0) and the ghost FSMs (requesters 1..NREQ-1).
//               One lookup is granted per cycle (round-robin), the ROM port
//               is driven from a registered issue stage, and the returned
//               exit nibble {left, up, right, down} is routed back to the
//               owner ROM_LAT+1 cycles after the grant. Out-of-range lookups
//               are granted but never touch the ROM and answer 0 (wall).
//               Ports:
//                 clk     : clock
//                 reset_n : asynchronous active-low reset
//                 bus     : maze_port_arbiter_if.slave (requests, grants,
//                           responses and the ROM port)
//               Optional build macro:
//                 MAZE_ARB_PAC_PRIORITY_EN - requester 0 gets strict priority,
//                 round-robin only among 1..NREQ-1.
//               NREQ must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module maze_port_arbiter #(
   parameter int NREQ    = 4,
   parameter int X_W     = 10,
   parameter int Y_W     = 10,
   parameter int XMAX    = 640,
   parameter int YMAX    = 480,
   parameter int DATA_W  = 4,
   parameter int ROM_LAT = 2
) (
   input wire logic           clk,
   input wire logic           reset_n,
   maze_port_arbiter_if.slave bus
);

   localparam int              c_ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int              c_DEPTH   = ROM_LAT + 1;
   localparam int              c_LAST_I  = NREQ - 1;
   localparam logic [c_ID_W-1:0] c_LAST  = c_LAST_I[c_ID_W-1:0];
   localparam logic [X_W:0]    c_XMAX    = XMAX[X_W:0];
   localparam logic [Y_W:0]    c_YMAX    = YMAX[Y_W:0];
   localparam logic [NREQ-1:0] c_ONE     = {{(NREQ-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rom_en;
   logic [X_W-1:0]    r_rom_x;
   logic [Y_W-1:0]    r_rom_y;
   logic [c_ID_W-1:0] r_ptr;

   // In-flight tags: stage s holds the lookup issued s cycles ago.
   logic              r_tag_vld [c_DEPTH];
   logic [c_ID_W-1:0] r_tag_id  [c_DEPTH];
   logic              r_tag_oob [c_DEPTH];

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic [NREQ-1:0]   w_elig;
   logic              w_any;
   logic [c_ID_W-1:0] w_win;
   logic [c_ID_W-1:0] w_ptr_nxt;

   // A requester shown gnt this cycle is masked so a held req cannot be
   // granted on two consecutive cycles.
   assign w_elig = bus.req & ~r_gnt;

`ifdef MAZE_ARB_PAC_PRIORITY_EN
   // Pacman wins whenever eligible; ghosts rotate among themselves with the
   // pointer held in 1..NREQ-1 (ghost slot g is stored as g+1).
   localparam int                c_NG        = NREQ - 1;
   localparam logic [c_ID_W:0]   c_NG_W      = c_NG[c_ID_W:0];
   localparam int                c_PTR_RST_I = 1;
   localparam logic [c_ID_W-1:0] c_PTR_RST   = c_PTR_RST_I[c_ID_W-1:0];

   logic [2*c_NG-1:0] w_gdbl;
   logic [c_NG-1:0]   w_grot;
   logic [c_ID_W-1:0] w_gptr;
   logic [c_ID_W-1:0] w_goff;
   logic [c_ID_W:0]   w_gsum;
   logic              w_gany;

   always_comb begin
      w_gptr    = r_ptr - 1'b1;
      w_gdbl    = {w_elig[NREQ-1:1], w_elig[NREQ-1:1]};
      w_grot    = w_gdbl[w_gptr +: c_NG];
      w_gany    = 1'b0;
      w_goff    = '0;
      // Descending scan leaves the lowest rotated offset as the winner.
      for (int k = c_NG - 1; k >= 0; k--) begin
         if (w_grot[k]) begin
            w_gany = 1'b1;
            w_goff = c_ID_W'(k);
         end
      end
      w_gsum = {1'b0, w_gptr} + {1'b0, w_goff};
      if (w_gsum >= c_NG_W) begin
         w_gsum = w_gsum - c_NG_W;
      end

      w_any     = 1'b0;
      w_win     = '0;
      w_ptr_nxt = r_ptr;
      if (w_elig[0]) begin
         w_any = 1'b1;
      end else if (w_gany) begin
         w_any     = 1'b1;
         w_win     = w_gsum[c_ID_W-1:0] + 1'b1;
         w_ptr_nxt = (w_win == c_LAST) ? c_PTR_RST : w_win + 1'b1;
      end
   end
`else
   localparam logic [c_ID_W:0]   c_NREQ_W  = NREQ[c_ID_W:0];
   localparam logic [c_ID_W-1:0] c_PTR_RST = '0;

   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [c_ID_W-1:0] w_off;
   logic [c_ID_W:0]   w_sum;

   // Rotate the eligible vector so bit 0 is the pointer position, pick the
   // lowest set bit, then rotate the offset back to an absolute index.
   always_comb begin
      w_dbl = {w_elig, w_elig};
      w_rot = w_dbl[r_ptr +: NREQ];
      w_any = 1'b0;
      w_off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_any = 1'b1;
            w_off = c_ID_W'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= c_NREQ_W) begin
         w_sum = w_sum - c_NREQ_W;
      end
      w_win     = w_sum[c_ID_W-1:0];
      w_ptr_nxt = r_ptr;
      if (w_any) begin
         w_ptr_nxt = (w_win == c_LAST) ? '0 : w_win + 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Winner's coordinates and range check
   // ---------------------------------------------------------------------
   logic [X_W-1:0]  w_win_x;
   logic [Y_W-1:0]  w_win_y;
   logic            w_win_oob;
   logic [NREQ-1:0] w_win_oh;

   assign w_win_x   = bus.req_x[int'(w_win) * X_W +: X_W];
   assign w_win_y   = bus.req_y[int'(w_win) * Y_W +: Y_W];
   assign w_win_oob = ({1'b0, w_win_x} >= c_XMAX) || ({1'b0, w_win_y} >= c_YMAX);
   assign w_win_oh  = c_ONE << w_win;

   // ---------------------------------------------------------------------
   // Issue stage, tag pipeline and response stage
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rom_en    <= 1'b0;
         r_rom_x     <= '0;
         r_rom_y     <= '0;
         r_ptr       <= c_PTR_RST;
         for (int s = 0; s < c_DEPTH; s++) begin
            r_tag_vld[s] <= 1'b0;
            r_tag_id[s]  <= '0;
            r_tag_oob[s] <= 1'b0;
         end
      end else begin
         r_gnt    <= w_any ? w_win_oh : '0;
         r_rom_en <= w_any & ~w_win_oob;
         // An out-of-range lookup leaves the ROM address untouched.
         if (w_any && !w_win_oob) begin
            r_rom_x <= w_win_x;
            r_rom_y <= w_win_y;
         end
         r_ptr <= w_ptr_nxt;

         r_tag_vld[0] <= w_any;
         r_tag_id[0]  <= w_win;
         r_tag_oob[0] <= w_win_oob;
         for (int s = 1; s < c_DEPTH; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_id[s]  <= r_tag_id[s-1];
            r_tag_oob[s] <= r_tag_oob[s-1];
         end

         // The last tag stage lines up with rom_data for its own lookup.
         r_rsp_valid <= r_tag_vld[c_DEPTH-1] ? (c_ONE << r_tag_id[c_DEPTH-1]) : '0;
         r_rsp_data  <= (r_tag_vld[c_DEPTH-1] && !r_tag_oob[c_DEPTH-1]) ? bus.rom_data : '0;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rom_en    = r_rom_en;
   assign bus.rom_x     = r_rom_x;
   assign bus.rom_y     = r_rom_y;

endmodule

`default_nettype wire

// File: tb/tb_maze_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_port_arbiter
// Description : Scoreboard bench for maze_port_arbiter. Requesters follow the
//               hold-until-grant contract; a reference model predicts grants,
//               ROM address and responses; a monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_port_arbiter;
   localparam int NREQ = 4, X_W = 10, Y_W = 10, XMAX = 640, YMAX = 480;
   localparam int DATA_W = 4, ROM_LAT = 2;
`ifdef MAZE_ARB_PAC_PRIORITY_EN
   localparam int PTR0 = 1;
`else
   localparam int PTR0 = 0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   maze_port_arbiter_if #(.NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) bus ();

   maze_port_arbiter #(
      .NREQ(NREQ), .X_W(X_W), .Y_W(Y_W), .XMAX(XMAX), .YMAX(YMAX),
      .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave)
   );

   function automatic logic [DATA_W-1:0] romf(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      int v;
      v = int'(x) * 5 + int'(y) * 3 + (int'(x) >> 3);
      return DATA_W'(v);
   endfunction

   // Maze ROM with ROM_LAT cycles of read latency; garbage when not enabled.
   logic [DATA_W-1:0] rom_pipe [ROM_LAT];
   always @(posedge clk) begin
      rom_pipe[0] <= bus.rom_en ? romf(bus.rom_x, bus.rom_y) : DATA_W'($urandom);
      for (int s = 1; s < ROM_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
   end
   assign bus.rom_data = rom_pipe[ROM_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct {
      int              cyc;
      logic [NREQ-1:0] g;
      logic            en;
      logic [X_W-1:0]  x;
      logic [Y_W-1:0]  y;
   } gexp_t;
   typedef struct {
      int                cyc;
      logic [NREQ-1:0]   v;
      logic [DATA_W-1:0] d;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t ge;
   rexp_t re;

   // Monitor: sample one time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (!reset_n) begin
         chk("reset_gnt", 32'(bus.gnt), 0);
         chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
         chk("reset_rsp_data", 32'(bus.rsp_data), 0);
         chk("reset_rom_en", 32'(bus.rom_en), 0);
         chk("reset_rom_x", 32'(bus.rom_x), 0);
         chk("reset_rom_y", 32'(bus.rom_y), 0);
      end else begin
         if (gq.size() > 0 && gq[0].cyc == cyc) begin
            ge = gq.pop_front();
            chk("gnt", 32'(bus.gnt), 32'(ge.g));
            chk("rom_en", 32'(bus.rom_en), 32'(ge.en));
            chk("rom_x", 32'(bus.rom_x), 32'(ge.x));
            chk("rom_y", 32'(bus.rom_y), 32'(ge.y));
         end else begin
            chk("idle_gnt", 32'(bus.gnt), 0);
            chk("idle_rom_en", 32'(bus.rom_en), 0);
         end
         if (rq.size() > 0 && rq[0].cyc == cyc) begin
            re = rq.pop_front();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(re.v));
            chk("rsp_data", 32'(bus.rsp_data), 32'(re.d));
         end else begin
            chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
         end
      end
   end

   // Requester state and reference model state.
   bit              pend [NREQ];
   logic [X_W-1:0]  px   [NREQ];
   logic [Y_W-1:0]  py   [NREQ];
   logic [NREQ-1:0] mgnt;     // grant the DUT should be showing this cycle
   int              mptr;
   logic [X_W-1:0]  mlx;
   logic [Y_W-1:0]  mly;

   task automatic model_reset();
      mgnt = '0;
      mptr = PTR0;
      mlx  = '0;
      mly  = '0;
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      gq.delete();
      rq.delete();
   endtask

   // Predict the decision made at the coming clock edge.
   task automatic model_decide();
      logic [NREQ-1:0] elig;
      int w;
      int e;
      bit oob;
      for (int i = 0; i < NREQ; i++) elig[i] = pend[i] & ~mgnt[i];
      w = -1;
`ifdef MAZE_ARB_PAC_PRIORITY_EN
      if (elig[0]) w = 0;
      else begin
         for (int k = 0; k < NREQ - 1; k++) begin
            int c;
            c = 1 + (mptr - 1 + k) % (NREQ - 1);
            if (w < 0 && elig[c]) w = c;
         end
         if (w > 0) mptr = (w == NREQ - 1) ? 1 : w + 1;
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         int c;
         c = (mptr + k) % NREQ;
         if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) mptr = (w + 1) % NREQ;
`endif
      e    = cyc + 1;
      mgnt = '0;
      if (w >= 0) begin
         oob = (int'(px[w]) >= XMAX) || (int'(py[w]) >= YMAX);
         mgnt[w] = 1'b1;
         if (!oob) begin
            mlx = px[w];
            mly = py[w];
         end
         gq.push_back('{e, mgnt, !oob, mlx, mly});
         rq.push_back('{e + 1 + ROM_LAT, mgnt, oob ? DATA_W'(0) : romf(px[w], py[w])});
      end
   endtask

   task automatic step_begin();
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (mgnt[i]) pend[i] = 1'b0;
   endtask

   task automatic post(input int i, input int x, input int y);
      if (!pend[i]) begin
         pend[i] = 1'b1;
         px[i]   = X_W'(x);
         py[i]   = Y_W'(y);
      end
   endtask

   task automatic post_rand(input int i);
      int x;
      int y;
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(XMAX, 1023)) : int'($urandom_range(0, XMAX - 1));
      y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(YMAX, 1023)) : int'($urandom_range(0, YMAX - 1));
      post(i, x, y);
   endtask

   task automatic step_end();
      for (int i = 0; i < NREQ; i++) begin
         bus.req[i]                 = pend[i];
         bus.req_x[i*X_W +: X_W]    = px[i];
         bus.req_y[i*Y_W +: Y_W]    = py[i];
      end
      model_decide();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step_begin();
         step_end();
      end
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         px[i] = '0;
         py[i] = '0;
      end
      model_reset();
      bus.req   = '0;
      bus.req_x = '0;
      bus.req_y = '0;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Single in-range lookup from pacman.
      step_begin(); post(0, 300, 300); step_end();
      idle(6);

      // All four pulse together, each drops after its grant.
      step_begin(); for (int i = 0; i < NREQ; i++) post(i, 100 + 37 * i, 50 + 91 * i); step_end();
      idle(8);

      // Requesters 1 and 3 hold req continuously.
      repeat (8) begin
         step_begin(); post_rand(1); post_rand(3); step_end();
      end
      idle(6);

      // Out-of-range lookups (x and y edges).
      step_begin(); post(2, 640, 10); step_end();
      idle(6);
      step_begin(); post(1, 639, 480); step_end();
      idle(6);

      // Everyone holding req.
      repeat (8) begin
         step_begin(); for (int i = 0; i < NREQ; i++) post_rand(i); step_end();
      end
      idle(6);

      // Randomized traffic.
      repeat (400) begin
         step_begin();
         for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 2) == 0) post_rand(i);
         step_end();
      end
      idle(10);

      // Three lookups in flight, then reset in the cycle after the third grant.
      step_begin(); post_rand(1); post_rand(2); step_end();
      step_begin(); step_end();
      step_begin(); post(1, 200, 200); step_end();
      step_begin();
      reset_n = 1'b0;
      bus.req = '0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      idle(6);

      // Arbitration restarts from the reset pointer.
      step_begin(); for (int i = 0; i < NREQ; i++) post(i, 10 * i, 20 * i); step_end();
      idle(10);

      chk("grant_queue_drained", 32'(gq.size()), 0);
      chk("response_queue_drained", 32'(rq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/maze_port_arbiter.md
# maze_port_arbiter

Shares the single-port maze/intersection ROM between the pacman movement FSM and the ghost movement FSMs. Each requester posts an (x, y) maze lookup. The block grants one requester per cycle, drives the ROM port, and routes the returned 4-bit exit nibble {left, up, right, down} back to the owner. The block sits between the movement controllers and the maze ROM. It is fully pipelined: up to one lookup is issued per cycle.

## Interface
Parameters:
- NREQ, 4: number of requesters; index 0 is pacman, indices 1..NREQ-1 are ghosts.
- X_W, 10: x coordinate width.
- Y_W, 10: y coordinate width.
- XMAX, 640: legal x is 0..XMAX-1.
- YMAX, 480: legal y is 0..YMAX-1.
- DATA_W, 4: ROM data width.
- ROM_LAT, 2: cycles from rom_en to valid rom_data; minimum 1.

Ports:
- clk, input, 1: clock; single clock domain.
- reset_n, input, 1: reset, asynchronous, active-low.
- req, input, NREQ: per-requester lookup request; level-sensitive.
- req_x, input, NREQ*X_W: packed x coordinates; slice i belongs to requester i.
- req_y, input, NREQ*Y_W: packed y coordinates.
- gnt, output, NREQ: one-hot, one-cycle grant pulse.
- rsp_valid, output, NREQ: one-hot, one-cycle response pulse.
- rsp_data, output, DATA_W: response nibble; meaningful only while rsp_valid is nonzero.
- rom_en, output, 1: ROM read strobe.
- rom_x, output, X_W: ROM x address.
- rom_y, output, Y_W: ROM y address.
- rom_data, input, DATA_W: ROM read data.

## Operation
- Eligible set in cycle T: req & ~gnt. A requester being granted this cycle is masked, so a held req is not granted twice back-to-back.
- Requester contract:
  - Hold req, req_x and req_y stable until gnt is seen.
  - Deassert req the cycle after gnt, or keep it high to post a new lookup. A held req is re-arbitrated from cycle T+2.
- Round-robin arbitration:
  - Pointer ptr (0..NREQ-1) starts at 0.
  - The winner is the first eligible index scanning ptr, ptr+1, … mod NREQ.
  - After a grant to index w, ptr <= (w+1) mod NREQ. ptr holds when there is no grant.
- Issue stage (registered from the T decision):
  - gnt[w] pulses.
  - rom_x and rom_y take the winner's coordinates.
  - A tag {valid, id, oob} enters a ROM_LAT+1 deep shift register.
- Out-of-range request (x >= XMAX or y >= YMAX):
  - Still granted and still consumes a slot.
  - rom_en stays 0 and rom_x/rom_y hold their previous values.
  - The response is delivered with identical latency and rsp_data = 0 (all exits closed, treated as wall).
- Response stage:
  - When a tag leaves the shift register, rsp_valid[id] = 1.
  - rsp_data is the registered rom_data, or 0 if oob.
- Responses return strictly in issue order. No reordering and no backpressure: requesters must accept rsp_valid whenever it is presented.
- The pipeline never stalls. The next lookup may issue the cycle after any other.
- Reset values: gnt = 0, rsp_valid = 0, rsp_data = 0, rom_en = 0, rom_x = 0, rom_y = 0, ptr = 0, all tags invalid.
- Reset asserted mid-operation: all in-flight lookups are discarded and no stale rsp_valid appears after release.

## Timing
- Cycle T: req sampled and winner chosen combinationally from req and ptr.
- Cycle T+1: gnt, rom_en, rom_x and rom_y are valid.
- Cycle T+1+ROM_LAT: rom_data is valid at the ROM port and is registered by this block.
- Cycle T+2+ROM_LAT: rsp_valid and rsp_data are presented. With ROM_LAT=2 this is T+4.
- Throughput: one lookup per cycle sustained.
- Worst-case grant wait for a requester with continuously asserted req is NREQ-1 grants to others.
- All outputs are registered; no combinational path from req to gnt.

## Configuration
- MAZE_ARB_PAC_PRIORITY_EN defined:
  - Requester 0 (pacman) has strict priority over all others whenever it is eligible.
  - Round-robin applies only among indices 1..NREQ-1 when requester 0 is not eligible.
  - ptr covers 1..NREQ-1 and does not advance on a pacman grant.
  - The gnt masking rule still applies, so pacman holding req gets at most every other cycle.
- Undefined: pure round-robin over all NREQ requesters as described above.

## Test plan
- Single request: req=0001, (x,y)=(300,300), rom_data=4'b1010 at T+3 -> gnt=0001 at T+1, rom_en=1 with rom_x=300/rom_y=300 at T+1, rsp_valid=0001 with rsp_data=4'b1010 at T+4.
- All four requesters pulse req=1111 in cycle 0 and each drops req after its gnt -> grants 0001, 0010, 0100, 1000 on cycles 1..4; responses arrive in the same order on cycles 4..7, each with its own ROM data.
- Requesters 1 and 3 hold req continuously for 8 cycles -> gnt alternates 0010, 1000, … and neither is granted on two consecutive cycles.
- Out-of-range request: req=0100 with x=640, y=10 -> gnt=0100, rom_en stays 0, and rsp_valid=0100 with rsp_data=0 at T+4.
- Reset mid-flight: issue 3 lookups, assert reset_n=0 at the cycle after the third grant, release 2 cycles later -> all outputs 0 during reset, no rsp_valid after release, and the next grant starts from index 0.
- With MAZE_ARB_PAC_PRIORITY_EN, req held at 1111 -> gnt sequence 0001, 0010, 0001, 0100, 0001, 1000.
